// File: rtl/dds_pkg.sv
// Shared definitions for the DDS amplitude meter: default widths and FSM encoding.
package dds_pkg;

    localparam int DATA_BIT_DEF = 14;
    localparam int WIN_W_DEF    = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACQ    = ST_ACQ,
        S_REPORT = ST_REPORT
    } meter_state_t;

endpackage

// File: rtl/dds_minmax_tracker.sv
// Running signed max/min of the accepted samples in the current window.
module dds_minmax_tracker
    import dds_pkg::*;
#(
    parameter int DATA_BIT = DATA_BIT_DEF
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [DATA_BIT-1:0] sample,
    output logic signed [DATA_BIT-1:0] max,
    output logic signed [DATA_BIT-1:0] min
);

    logic first_reg;

    // The first sample after clr seeds both trackers so no sentinel values are needed.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            first_reg <= 1'b1;
            max       <= '0;
            min       <= '0;
        end else if (clr) begin
            first_reg <= 1'b1;
        end else if (en) begin
            first_reg <= 1'b0;
            if (first_reg) begin
                max <= sample;
                min <= sample;
            end else begin
                if (sample > max) max <= sample;
                if (sample < min) min <= sample;
            end
        end
    end

endmodule

// File: rtl/dds_amp_meter.sv
// Windowed amplitude meter: tracks max/min over win_len valid samples, then reports pp and amp.
module dds_amp_meter
    import dds_pkg::*;
#(
    parameter int DATA_BIT = DATA_BIT_DEF,
    parameter int WIN_W    = WIN_W_DEF
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIN_W-1:0]           win_len,
    input  logic signed [DATA_BIT-1:0] dds_data,
    input  logic                       dds_data_en,
    output logic                       busy,
    output logic signed [DATA_BIT-1:0] meas_max,
    output logic signed [DATA_BIT-1:0] meas_min,
    output logic [DATA_BIT:0]          meas_pp,
    output logic [DATA_BIT-1:0]        meas_amp,
    output logic                       meas_valid
);

    meter_state_t              state_reg;
    logic [WIN_W-1:0]          cnt_reg;
    logic                      trk_clr;
    logic                      trk_en;
    logic signed [DATA_BIT-1:0] trk_max;
    logic signed [DATA_BIT-1:0] trk_min;
    logic [DATA_BIT:0]         pp_next;

    assign trk_clr = (state_reg == S_IDLE) && start;
    // abort wins over a coincident sample, so that sample never reaches the trackers
    assign trk_en  = (state_reg == S_ACQ) && dds_data_en && !abort;

    dds_minmax_tracker #(
        .DATA_BIT (DATA_BIT)
    ) u_tracker (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clr     (trk_clr),
        .en      (trk_en),
        .sample  (dds_data),
        .max     (trk_max),
        .min     (trk_min)
    );

    // One extra bit of sign extension makes max-min exact for any pair of samples.
    assign pp_next = {trk_max[DATA_BIT-1], trk_max} - {trk_min[DATA_BIT-1], trk_min};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            busy       <= 1'b0;
            meas_max   <= '0;
            meas_min   <= '0;
            meas_pp    <= '0;
            meas_amp   <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cnt_reg   <= (win_len == '0) ? WIN_W'(1) : win_len;
                        busy      <= 1'b1;
                        state_reg <= S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (dds_data_en) begin
                        cnt_reg <= cnt_reg - WIN_W'(1);
                        if (cnt_reg == WIN_W'(1)) state_reg <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    meas_max   <= trk_max;
                    meas_min   <= trk_min;
                    meas_pp    <= pp_next;
                    meas_amp   <= pp_next[DATA_BIT:1];
                    meas_valid <= 1'b1;
                    busy       <= 1'b0;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_amp_meter.sv
// Directed bench for dds_amp_meter: inputs driven and outputs sampled on the falling edge.
module tb_dds_amp_meter;

    logic               sys_clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [15:0]        win_len;
    logic signed [13:0] dds_data;
    logic               dds_data_en;
    logic               busy;
    logic signed [13:0] meas_max;
    logic signed [13:0] meas_min;
    logic [14:0]        meas_pp;
    logic [13:0]        meas_amp;
    logic               meas_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    dds_amp_meter dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .win_len     (win_len),
        .dds_data    (dds_data),
        .dds_data_en (dds_data_en),
        .busy        (busy),
        .meas_max    (meas_max),
        .meas_min    (meas_min),
        .meas_pp     (meas_pp),
        .meas_amp    (meas_amp),
        .meas_valid  (meas_valid)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic begin_meas(input int wl);
        start   = 1'b1;
        win_len = 16'(wl);
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input int s);
        dds_data    = 14'(s);
        dds_data_en = 1'b1;
        tick();
        dds_data_en = 1'b0;
    endtask

    task automatic gap();
        dds_data    = 14'sd1234;
        dds_data_en = 1'b0;
        tick();
    endtask

    // Called right after the last sample edge; leaves time at the cycle where meas_valid is high.
    task automatic expect_report(input string tag, input int emax, input int emin,
                                 input int epp, input int eamp);
        chk({tag, "_valid_early"}, int'(meas_valid), 0);
        tick();
        chk({tag, "_valid"}, int'(meas_valid), 1);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_max"},   int'(meas_max), emax);
        chk({tag, "_min"},   int'(meas_min), emin);
        chk({tag, "_pp"},    int'(meas_pp), epp);
        chk({tag, "_amp"},   int'(meas_amp), eamp);
        $display("%s: max=%0d min=%0d pp=%0d amp=%0d", tag, meas_max, meas_min, meas_pp, meas_amp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; win_len = '0;
        dds_data = '0; dds_data_en = 1'b0;
        tick(); tick();
        chk("rst_busy",  int'(busy), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_max",   int'(meas_max), 0);
        chk("rst_pp",    int'(meas_pp), 0);
        rst_n = 1'b1;
        tick();

        // Test 1: continuous samples; win_len changed mid-window must not matter.
        begin_meas(4);
        chk("t1_busy", int'(busy), 1);
        send(100);
        win_len = 16'd1;
        send(-50);
        send(300);
        chk("t1_busy_mid", int'(busy), 1);
        send(-200);
        expect_report("t1", 300, -200, 500, 250);
        tick();
        chk("t1_valid_fall", int'(meas_valid), 0);

        // Test 2: gapped samples.
        begin_meas(3);
        send(10); gap();
        send(20); gap();
        chk("t2_busy_mid", int'(busy), 1);
        chk("t2_novalid_mid", int'(meas_valid), 0);
        send(30);
        expect_report("t2", 30, 10, 20, 10);
        tick();

        // Test 3: full-scale swing; start issued during the meas_valid cycle.
        begin_meas(2);
        send(8191);
        send(-8192);
        expect_report("t3", 8191, -8192, 16383, 8191);
        start   = 1'b1;
        win_len = 16'd0;
        tick();
        start   = 1'b0;
        chk("t4_start_in_valid_busy", int'(busy), 1);
        chk("t4_valid_fall", int'(meas_valid), 0);

        // Test 4: win_len=0 means one sample.
        send(7);
        expect_report("t4", 7, 7, 0, 0);
        tick();

        // Test 5: abort mid-window, with a coincident sample that must be dropped.
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_idle_busy", int'(busy), 0);
        begin_meas(8);
        send(1000);
        send(-1000);
        abort = 1'b1; dds_data = 14'sd5000; dds_data_en = 1'b1;
        tick();
        abort = 1'b0; dds_data_en = 1'b0;
        chk("t5_busy_drop", int'(busy), 0);
        chk("t5_novalid", int'(meas_valid), 0);
        tick();
        chk("t5_novalid2", int'(meas_valid), 0);
        chk("t5_max_hold", int'(meas_max), 7);
        chk("t5_pp_hold", int'(meas_pp), 0);
        // start and abort together in IDLE: start wins, window is fresh.
        start = 1'b1; abort = 1'b1; win_len = 16'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_start_wins", int'(busy), 1);
        send(50);
        send(60);
        expect_report("t5", 60, 50, 10, 5);
        tick();

        // Test 6a: start during ACQ is ignored (no reload of the count).
        begin_meas(5);
        send(1);
        send(2);
        start = 1'b1; win_len = 16'd2;
        send(3);
        start = 1'b0;
        send(4);
        chk("t6_ign_busy", int'(busy), 1);
        chk("t6_ign_novalid", int'(meas_valid), 0);
        send(5);
        expect_report("t6", 5, 1, 4, 2);
        tick();

        // Test 6b: reset mid-window clears everything.
        begin_meas(4);
        send(-77);
        send(99);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_valid", int'(meas_valid), 0);
        chk("t6_rst_max", int'(meas_max), 0);
        chk("t6_rst_min", int'(meas_min), 0);
        chk("t6_rst_pp", int'(meas_pp), 0);
        chk("t6_rst_amp", int'(meas_amp), 0);
        rst_n = 1'b1;
        tick();
        begin_meas(1);
        send(-3);
        expect_report("t6r", -3, -3, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
